// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM bus arbiter: access size encodings,
// arbiter FSM states and the default SRAM access length.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int ACCESS_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Half accesses need addr[0]=0, word (and the 11 encoding) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic w_bad;
    case (size)
      SIZE_BYTE: w_bad = 1'b0;
      SIZE_HALF: w_bad = addr_lo[0];
      default:   w_bad = |addr_lo;
    endcase
    return w_bad;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the byte/half lane selected by the low address
// bits out of the raw SRAM word and sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane extraction followed by extension according to access size.
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0: w_byte = i_raw[7:0];
      2'd1: w_byte = i_raw[15:8];
      2'd2: w_byte = i_raw[23:16];
      2'd3: w_byte = i_raw[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];
    case (i_size)
      SIZE_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SIZE_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default:   o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Owns the single SRAM controller port for the CPU. Data (MEM-stage)
// requests win over instruction fetches; the winner is latched for the
// whole access. Each access is IDLE -> ACCESS (ACCESS_CYCLES) -> RESP, or
// IDLE -> RESP directly for a misaligned data access.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no access; sample requests, data first
// ST_ACCESS | request driven stable toward SRAM, down-counter running
// ST_RESP   | one-cycle ready pulse to the granted requester
module sram_bus_arbiter
  import mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_signed_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        mem_addr_err_o,
  output logic        stall_o,
  output logic        ramReq_o,
  output logic        ramOp_o,
  output logic [19:0] ramAddr_o,
  output logic [31:0] storeData_o,
  output logic [3:0]  byteEnable_n_o,
  input  logic [31:0] loadData_i
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_mem;
  logic               r_err;
  logic               r_we;
  logic [1:0]         r_size;
  logic               r_signed;
  logic [1:0]         r_addr_lo;
  logic               r_ram_req;
  logic               r_ram_op;
  logic [19:0]        r_ram_addr;
  logic [31:0]        r_store_data;
  logic [3:0]         r_be_n;
  logic [31:0]        r_mem_rdata;
  logic [31:0]        r_if_data;

  logic               w_start;
  logic               w_misal;
  logic [31:0]        w_sel_addr;
  logic [31:0]        w_store_data;
  logic [3:0]         w_be_n;
  logic [31:0]        w_aligned;
  logic               w_unused;

  // Upper address bits are outside the 4 MiB SRAM window.
  assign w_unused = &{1'b0, if_addr_i[31:22], if_addr_i[1:0], mem_addr_i[31:22]};

  // State register.
  always_ff @(posedge clk50 or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; data requests are checked before fetches.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_misal = is_misaligned(mem_size_i, mem_addr_i[1:0]);
    case (r_state)
      ST_IDLE: begin
        if (mem_req_i) begin
          w_start = 1'b1;
          w_next  = w_misal ? ST_RESP : ST_ACCESS;
        end else if (if_req_i) begin
          w_start = 1'b1;
          w_next  = ST_ACCESS;
        end
      end
      ST_ACCESS: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Store lane replication and byte enables; loads and fetches read all lanes.
  always_comb begin
    w_sel_addr   = mem_req_i ? mem_addr_i : if_addr_i;
    w_store_data = mem_wdata_i;
    w_be_n       = 4'h0;
    if (mem_req_i && mem_we_i) begin
      case (mem_size_i)
        SIZE_BYTE: begin
          w_store_data = {4{mem_wdata_i[7:0]}};
          w_be_n       = ~(4'b0001 << mem_addr_i[1:0]);
        end
        SIZE_HALF: begin
          w_store_data = {2{mem_wdata_i[15:0]}};
          w_be_n       = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        end
        default: begin
          w_store_data = mem_wdata_i;
          w_be_n       = 4'h0;
        end
      endcase
    end
  end

  mem_load_align u_load_align (
    .i_raw     (loadData_i),
    .i_size    (r_size),
    .i_signed  (r_signed),
    .i_addr_lo (r_addr_lo),
    .o_data    (w_aligned)
  );

  // Access datapath: latch the grant on start, hold the SRAM request stable
  // through ACCESS, capture read data on the last ACCESS cycle.
  always_ff @(posedge clk50 or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_is_mem     <= 1'b0;
      r_err        <= 1'b0;
      r_we         <= 1'b0;
      r_size       <= SIZE_BYTE;
      r_signed     <= 1'b0;
      r_addr_lo    <= 2'b00;
      r_ram_req    <= 1'b0;
      r_ram_op     <= 1'b0;
      r_ram_addr   <= '0;
      r_store_data <= '0;
      r_be_n       <= 4'hF;
      r_mem_rdata  <= '0;
      r_if_data    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_is_mem  <= mem_req_i;
            r_err     <= mem_req_i & w_misal;
            r_we      <= mem_req_i & mem_we_i;
            r_size    <= mem_size_i;
            r_signed  <= mem_signed_i;
            r_addr_lo <= mem_addr_i[1:0];
            r_cnt     <= CNT_W'(ACCESS_CYCLES - 1);
            if (mem_req_i && w_misal) begin
              r_mem_rdata <= '0;
            end else begin
              r_ram_req    <= 1'b1;
              r_ram_op     <= mem_req_i & mem_we_i;
              r_ram_addr   <= w_sel_addr[21:2];
              r_store_data <= w_store_data;
              r_be_n       <= w_be_n;
            end
          end
        end
        ST_ACCESS: begin
          if (r_cnt == '0) begin
            r_ram_req <= 1'b0;
            r_ram_op  <= 1'b0;
            r_be_n    <= 4'hF;
            if (r_is_mem) r_mem_rdata <= r_we ? 32'h0 : w_aligned;
            else          r_if_data   <= loadData_i;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ramReq_o       = r_ram_req;
  assign ramOp_o        = r_ram_op;
  assign ramAddr_o      = r_ram_addr;
  assign storeData_o    = r_store_data;
  assign byteEnable_n_o = r_be_n;
  assign mem_rdata_o    = r_mem_rdata;
  assign if_data_o      = r_if_data;
  assign mem_ready_o    = (r_state == ST_RESP) &  r_is_mem;
  assign if_ready_o     = (r_state == ST_RESP) & ~r_is_mem;
  assign mem_addr_err_o = mem_ready_o & r_err;
  assign stall_o        = (if_req_i & ~if_ready_o) | (mem_req_i & ~mem_ready_o);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with ACCESS_CYCLES=2. Inputs change
// on the falling edge; outputs are sampled on the falling edge.
module tb_sram_bus_arbiter;
  import mem_pkg::*;

  logic        clk50 = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic        mem_signed_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;
  logic        mem_addr_err_o;
  logic        stall_o;
  logic        ramReq_o;
  logic        ramOp_o;
  logic [19:0] ramAddr_o;
  logic [31:0] storeData_o;
  logic [3:0]  byteEnable_n_o;
  logic [31:0] loadData_i;

  int errors = 0;
  int checks = 0;

  always #5 clk50 = ~clk50;

  sram_bus_arbiter #(.ACCESS_CYCLES(2)) dut (
    .clk50          (clk50),
    .rst            (rst),
    .if_req_i       (if_req_i),
    .if_addr_i      (if_addr_i),
    .if_data_o      (if_data_o),
    .if_ready_o     (if_ready_o),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_size_i     (mem_size_i),
    .mem_signed_i   (mem_signed_i),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_rdata_o    (mem_rdata_o),
    .mem_ready_o    (mem_ready_o),
    .mem_addr_err_o (mem_addr_err_o),
    .stall_o        (stall_o),
    .ramReq_o       (ramReq_o),
    .ramOp_o        (ramOp_o),
    .ramAddr_o      (ramAddr_o),
    .storeData_o    (storeData_o),
    .byteEnable_n_o (byteEnable_n_o),
    .loadData_i     (loadData_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Clocks until the wanted ready is seen (bounded), recording what the
  // SRAM side showed while ramReq_o was high.
  task automatic run(input bit want_mem, output int lat, output int req_cyc, output int op_cyc,
                     output logic [19:0] a, output logic [31:0] sd, output logic [3:0] be,
                     output bit unstable, output bit stall_dropped);
    lat = 0; req_cyc = 0; op_cyc = 0; a = '0; sd = '0; be = 4'hF;
    unstable = 1'b0; stall_dropped = 1'b0;
    while (lat < 20) begin
      @(posedge clk50);
      @(negedge clk50);
      lat++;
      if (ramReq_o) begin
        if (req_cyc == 0) begin
          a = ramAddr_o; sd = storeData_o; be = byteEnable_n_o;
        end else if (a !== ramAddr_o || sd !== storeData_o || be !== byteEnable_n_o) begin
          unstable = 1'b1;
        end
        req_cyc++;
      end
      if (ramOp_o) op_cyc++;
      if (want_mem ? mem_ready_o : if_ready_o) break;
      if (!stall_o) stall_dropped = 1'b1;
    end
  endtask

  task automatic start_mem(input bit we, input logic [1:0] size, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
    mem_req_i = 1'b1; mem_we_i = we; mem_size_i = size; mem_signed_i = sgn;
    mem_addr_i = addr; mem_wdata_i = wdata;
  endtask

  task automatic drop_mem();
    mem_req_i = 1'b0;
    @(negedge clk50);
  endtask

  int          lat, rc, oc;
  logic [19:0] a;
  logic [31:0] sd;
  logic [3:0]  be;
  bit          uns, sdrop;

  initial begin
    rst = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = SIZE_WORD; mem_signed_i = 1'b0;
    mem_addr_i = '0; mem_wdata_i = '0; loadData_i = '0;
    repeat (2) @(negedge clk50);
    chk("reset ramReq", {31'b0, ramReq_o}, 32'd0);
    chk("reset be_n", {28'b0, byteEnable_n_o}, 32'hF);
    chk("reset ready", {30'b0, mem_ready_o, if_ready_o}, 32'd0);
    chk("reset rdata", mem_rdata_o, 32'd0);
    chk("reset ramAddr", {12'b0, ramAddr_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk50);

    // Load word 0x104
    loadData_i = 32'hDEADBEEF;
    start_mem(1'b0, SIZE_WORD, 1'b0, 32'h0000_0104, 32'h0);
    #1 chk("lw stall early", {31'b0, stall_o}, 32'd1);
    run(1'b1, lat, rc, oc, a, sd, be, uns, sdrop);
    chk("lw latency", lat, 3);
    chk("lw ramAddr", {12'b0, a}, 32'h41);
    chk("lw be_n", {28'b0, be}, 32'h0);
    chk("lw req cycles", rc, 2);
    chk("lw op cycles", oc, 0);
    chk("lw stable", {31'b0, uns}, 32'd0);
    chk("lw rdata", mem_rdata_o, 32'hDEADBEEF);
    chk("lw err", {31'b0, mem_addr_err_o}, 32'd0);
    chk("lw resp ramReq", {31'b0, ramReq_o}, 32'd0);
    chk("lw resp be_n", {28'b0, byteEnable_n_o}, 32'hF);
    drop_mem();
    chk("lw stall after", {31'b0, stall_o}, 32'd0);
    chk("lw ready one cycle", {31'b0, mem_ready_o}, 32'd0);

    // Signed / unsigned byte load at ...3
    loadData_i = 32'h80FF_1234;
    start_mem(1'b0, SIZE_BYTE, 1'b1, 32'h0000_0103, 32'h0);
    run(1'b1, lat, rc, oc, a, sd, be, uns, sdrop);
    chk("lbs latency", lat, 3);
    chk("lbs rdata", mem_rdata_o, 32'hFFFF_FF80);
    chk("lbs be_n", {28'b0, be}, 32'h0);
    drop_mem();
    start_mem(1'b0, SIZE_BYTE, 1'b0, 32'h0000_0103, 32'h0);
    run(1'b1, lat, rc, oc, a, sd, be, uns, sdrop);
    chk("lbu rdata", mem_rdata_o, 32'h0000_0080);
    drop_mem();

    // Signed half load at ...2 and unsigned half at ...0
    start_mem(1'b0, SIZE_HALF, 1'b1, 32'h0000_0002, 32'h0);
    run(1'b1, lat, rc, oc, a, sd, be, uns, sdrop);
    chk("lhs rdata", mem_rdata_o, 32'hFFFF_80FF);
    drop_mem();
    start_mem(1'b0, SIZE_HALF, 1'b0, 32'h0000_0000, 32'h0);
    run(1'b1, lat, rc, oc, a, sd, be, uns, sdrop);
    chk("lhu rdata", mem_rdata_o, 32'h0000_1234);
    drop_mem();

    // Store half 0xABCD at ...2
    start_mem(1'b1, SIZE_HALF, 1'b0, 32'h0000_0102, 32'h1234_ABCD);
    run(1'b1, lat, rc, oc, a, sd, be, uns, sdrop);
    chk("sh latency", lat, 3);
    chk("sh storeData", sd, 32'hABCD_ABCD);
    chk("sh be_n", {28'b0, be}, 32'h3);
    chk("sh ramAddr", {12'b0, a}, 32'h40);
    chk("sh op cycles", oc, 2);
    chk("sh stable", {31'b0, uns}, 32'd0);
    drop_mem();

    // Store byte 0x5A at ...1
    start_mem(1'b1, SIZE_BYTE, 1'b0, 32'h0000_0101, 32'hFFFF_FF5A);
    run(1'b1, lat, rc, oc, a, sd, be, uns, sdrop);
    chk("sb storeData", sd, 32'h5A5A_5A5A);
    chk("sb be_n", {28'b0, be}, 32'hD);
    drop_mem();

    // Store word at ...0x8
    start_mem(1'b1, SIZE_WORD, 1'b0, 32'h0000_0008, 32'h1122_3344);
    run(1'b1, lat, rc, oc, a, sd, be, uns, sdrop);
    chk("sw storeData", sd, 32'h1122_3344);
    chk("sw be_n", {28'b0, be}, 32'h0);
    drop_mem();

    // Simultaneous fetch and data: data first, fetch 4 cycles after
    loadData_i = 32'hCAFE_F00D;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0203;
    start_mem(1'b0, SIZE_WORD, 1'b0, 32'h0000_0008, 32'h0);
    run(1'b1, lat, rc, oc, a, sd, be, uns, sdrop);
    chk("both mem latency", lat, 3);
    chk("both mem ramAddr", {12'b0, a}, 32'h2);
    chk("both mem stall held", {31'b0, sdrop}, 32'd0);
    chk("both if_ready low", {31'b0, if_ready_o}, 32'd0);
    chk("both stall at mem ready", {31'b0, stall_o}, 32'd1);
    mem_req_i = 1'b0;
    run(1'b0, lat, rc, oc, a, sd, be, uns, sdrop);
    chk("both if gap", lat, 4);
    chk("both if ramAddr", {12'b0, a}, 32'h80);
    chk("both if op", oc, 0);
    chk("both if be_n", {28'b0, be}, 32'h0);
    chk("both if stall held", {31'b0, sdrop}, 32'd0);
    chk("both if data", if_data_o, 32'hCAFE_F00D);
    chk("both stall drops", {31'b0, stall_o}, 32'd0);
    chk("both no mem ready", {31'b0, mem_ready_o}, 32'd0);
    if_req_i = 1'b0;
    @(negedge clk50);

    // Misaligned word load at ...2
    start_mem(1'b0, SIZE_WORD, 1'b0, 32'h0000_0006, 32'h0);
    run(1'b1, lat, rc, oc, a, sd, be, uns, sdrop);
    chk("mis lw latency", lat, 1);
    chk("mis lw err", {31'b0, mem_addr_err_o}, 32'd1);
    chk("mis lw rdata", mem_rdata_o, 32'd0);
    chk("mis lw no ramReq", rc, 0);
    drop_mem();
    chk("mis err one cycle", {31'b0, mem_addr_err_o}, 32'd0);

    // Misaligned half store at ...1
    start_mem(1'b1, SIZE_HALF, 1'b0, 32'h0000_0001, 32'hFFFF);
    run(1'b1, lat, rc, oc, a, sd, be, uns, sdrop);
    chk("mis sh latency", lat, 1);
    chk("mis sh err", {31'b0, mem_addr_err_o}, 32'd1);
    chk("mis sh no ramReq", rc, 0);
    drop_mem();

    // Reset during the second ACCESS cycle, then restart of the held request
    loadData_i = 32'h1234_5678;
    start_mem(1'b0, SIZE_WORD, 1'b0, 32'h0000_0010, 32'h0);
    @(posedge clk50);
    @(posedge clk50);
    #1 chk("rst ramReq before", {31'b0, ramReq_o}, 32'd1);
    #1 rst = 1'b0;
    #1 chk("rst ramReq async", {31'b0, ramReq_o}, 32'd0);
    chk("rst be_n async", {28'b0, byteEnable_n_o}, 32'hF);
    @(posedge clk50);
    @(negedge clk50);
    chk("rst no ready", {31'b0, mem_ready_o}, 32'd0);
    chk("rst ramReq held low", {31'b0, ramReq_o}, 32'd0);
    rst = 1'b1;
    run(1'b1, lat, rc, oc, a, sd, be, uns, sdrop);
    chk("rst restart latency", lat, 3);
    chk("rst restart ramAddr", {12'b0, a}, 32'h4);
    chk("rst restart rdata", mem_rdata_o, 32'h1234_5678);
    drop_mem();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
